cdru: RTL and testbench

// Conflict Detection Read Unit: read-side counterpart of the banked-memory write arbiter.
// - Arbitrates three read requesters (i, d, c) onto one memory read port, fixed priority i > d > c.
// - Tracks each granted read through the memory's fixed read latency.
// - Steers returned data to the requester that issued the read, with a one-cycle rvalid pulse.
// - Sits between the MVU input/datapath/control read clients and one memory bank group.
//

---
 rtl/cdu_pkg.sv | 19 +
 rtl/cdru_latpipe.sv | 48 ++++
 rtl/cdru.sv | 107 ++++++++++
 tb/tb_cdru.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cdu_pkg.sv
// Shared read/write arbiter definitions: requester mux codes and latency limits.
package cdu_pkg;

  typedef logic [1:0] muxcode_t;

  localparam muxcode_t MUX_I = 2'd0;
  localparam muxcode_t MUX_D = 2'd1;
  localparam muxcode_t MUX_C = 2'd2;

  localparam int RDLAT_MAX = 8;

  // Priority i > d > c; only meaningful when at least one request is active.
  function automatic muxcode_t pick_code(input logic i_req, input logic d_req);
    if (i_req) return MUX_I;
    if (d_req) return MUX_D;
    return MUX_C;
  endfunction

endpackage

// File: rtl/cdru_latpipe.sv
// Resettable valid/tag shift register tracking reads through the memory latency.
module cdru_latpipe #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_tag,
  output logic         out_vld,
  output logic [W-1:0] out_tag,
  output logic         any_vld
);

  logic [DEPTH-1:0] vld_reg;
  logic [W-1:0]     tag_reg [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vld_reg[gi] <= 1'b0;
            tag_reg[gi] <= '0;
          end else begin
            vld_reg[gi] <= in_vld;
            tag_reg[gi] <= in_tag;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            vld_reg[gi] <= 1'b0;
            tag_reg[gi] <= '0;
          end else begin
            vld_reg[gi] <= vld_reg[gi-1];
            tag_reg[gi] <= tag_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  assign out_vld = vld_reg[DEPTH-1];
  assign out_tag = tag_reg[DEPTH-1];
  assign any_vld = |vld_reg;

endmodule

// File: rtl/cdru.sv
// Conflict detection read unit: fixed-priority read arbitration with tagged data return.
// Optional macro CDRU_RDATA_REG_EN registers the return path (one extra cycle of latency).
module cdru
  import cdu_pkg::*;
#(
  parameter int BANKBITS = 5,
  parameter int WORDBITS = 9,
  parameter int DATABITS = 64,
  parameter int RDLAT    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic [BANKBITS+WORDBITS-1:0] i_addr,
  output logic                         i_grnt,
  output logic [DATABITS-1:0]          i_rdata,
  output logic                         i_rvalid,
  input  logic                         d_en,
  input  logic [BANKBITS+WORDBITS-1:0] d_addr,
  output logic                         d_grnt,
  output logic [DATABITS-1:0]          d_rdata,
  output logic                         d_rvalid,
  input  logic                         c_en,
  input  logic [BANKBITS+WORDBITS-1:0] c_addr,
  output logic                         c_grnt,
  output logic [DATABITS-1:0]          c_rdata,
  output logic                         c_rvalid,
  output logic                         o_en,
  output logic [BANKBITS+WORDBITS-1:0] o_addr,
  input  logic [DATABITS-1:0]          m_rdata,
  output logic                         busy
);

  generate
    if (RDLAT < 1 || RDLAT > RDLAT_MAX) begin : g_bad_rdlat
      $error("cdru: RDLAT must be within 1..8");
    end
  endgenerate

  muxcode_t code;
  logic     ret_vld;
  muxcode_t ret_code;
  logic     pipe_busy;

  always_comb begin
    code   = pick_code(i_en, d_en);
    o_en   = i_en | d_en | c_en;
    i_grnt = i_en;
    d_grnt = d_en & ~i_en;
    c_grnt = c_en & ~i_en & ~d_en;
    case (code)
      MUX_I:   o_addr = i_addr;
      MUX_D:   o_addr = d_addr;
      default: o_addr = c_addr;
    endcase
  end

  cdru_latpipe #(
    .DEPTH (RDLAT),
    .W     (2)
  ) u_latpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (o_en),
    .in_tag  (code),
    .out_vld (ret_vld),
    .out_tag (ret_code),
    .any_vld (pipe_busy)
  );

  logic ret_i, ret_d, ret_c;
  assign ret_i = ret_vld && (ret_code == MUX_I);
  assign ret_d = ret_vld && (ret_code == MUX_D);
  assign ret_c = ret_vld && (ret_code == MUX_C);

`ifdef CDRU_RDATA_REG_EN
  // Each requester's data register only captures its own returns, so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      c_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
      c_rdata  <= '0;
    end else begin
      i_rvalid <= ret_i;
      d_rvalid <= ret_d;
      c_rvalid <= ret_c;
      if (ret_i) i_rdata <= m_rdata;
      if (ret_d) d_rdata <= m_rdata;
      if (ret_c) c_rdata <= m_rdata;
    end
  end

  assign busy = pipe_busy | i_rvalid | d_rvalid | c_rvalid;
`else
  assign i_rvalid = ret_i;
  assign d_rvalid = ret_d;
  assign c_rvalid = ret_c;
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;
  assign c_rdata  = m_rdata;
  assign busy     = pipe_busy;
`endif

endmodule

// File: tb/tb_cdru.sv
// Self-checking bench for cdru: directed scenarios plus randomized request traffic vs a scheduling model.
module tb_cdru;

  localparam int AW    = 14;
  localparam int DB    = 64;
  localparam int RDLAT = 3;
`ifdef CDRU_RDATA_REG_EN
  localparam int LAT = RDLAT + 1;
`else
  localparam int LAT = RDLAT;
`endif
  localparam int NSCHED = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_en   [3];
  logic [AW-1:0] req_addr [3];
  logic          grnt     [3];
  logic          rvalid   [3];
  logic [DB-1:0] rdata    [3];
  logic          o_en;
  logic [AW-1:0] o_addr;
  logic [DB-1:0] mdata;
  logic          busy;

  cdru #(.BANKBITS(5), .WORDBITS(9), .DATABITS(DB), .RDLAT(RDLAT)) dut (
    .clk(clk), .rst(rst),
    .i_en(req_en[0]), .i_addr(req_addr[0]), .i_grnt(grnt[0]), .i_rdata(rdata[0]), .i_rvalid(rvalid[0]),
    .d_en(req_en[1]), .d_addr(req_addr[1]), .d_grnt(grnt[1]), .d_rdata(rdata[1]), .d_rvalid(rvalid[1]),
    .c_en(req_en[2]), .c_addr(req_addr[2]), .c_grnt(grnt[2]), .c_rdata(rdata[2]), .c_rvalid(rvalid[2]),
    .o_en(o_en), .o_addr(o_addr), .m_rdata(mdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: sched[t] holds which requester (0=i,1=d,2=c) must see rvalid in cycle t, or -1.
  int            sched [NSCHED];
  int            cyc;
  logic          pend  [3];
  logic [AW-1:0] paddr [3];
  logic [DB-1:0] last  [3];
  int            checks   = 0;
  int            failures = 0;
  string         names [3] = '{"i", "d", "c"};

  task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    int   win;
    logic exp_busy;
    mdata = {$urandom, $urandom};
    for (int r = 0; r < 3; r++) begin
      req_en[r]   = rst ? 1'b0 : pend[r];
      req_addr[r] = paddr[r];
    end
    #1;
    win = -1;
    for (int r = 0; r < 3; r++) if (req_en[r] && win < 0) win = r;
    for (int r = 0; r < 3; r++) begin
      check({names[r], "_grnt"}, grnt[r], (win == r));
      check({names[r], "_rvalid"}, rvalid[r], (!rst && sched[cyc] == r));
`ifdef CDRU_RDATA_REG_EN
      check({names[r], "_rdata"}, rdata[r], last[r]);
`else
      check({names[r], "_rdata"}, rdata[r], mdata);
`endif
    end
    check("o_en", o_en, (win >= 0));
    if (win >= 0) check("o_addr", o_addr, paddr[win]);
    exp_busy = 1'b0;
    for (int t = cyc; t < cyc + LAT; t++) if (sched[t] != -1) exp_busy = 1'b1;
    check("busy", busy, (!rst && exp_busy));
    $display("cyc=%0d rst=%0b en=%0b%0b%0b win=%0d rvalid=%0b%0b%0b busy=%0b",
             cyc, rst, req_en[0], req_en[1], req_en[2], win, rvalid[0], rvalid[1], rvalid[2], busy);
    @(posedge clk);
    if (!rst) begin
`ifdef CDRU_RDATA_REG_EN
      for (int r = 0; r < 3; r++) if (sched[cyc+1] == r) last[r] = mdata;
`endif
      if (win >= 0) begin
        sched[cyc+LAT] = win;
        pend[win] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset(input int ncyc);
    rst = 1'b1;
    for (int t = cyc; t < NSCHED; t++) sched[t] = -1;
    for (int r = 0; r < 3; r++) begin
      last[r] = '0;
      pend[r] = 1'b0;
    end
    for (int k = 0; k < ncyc; k++) step();
    rst = 1'b0;
  endtask

  task automatic request(input int r);
    pend[r]  = 1'b1;
    paddr[r] = AW'($urandom);
  endtask

  initial begin
    cyc = 0;
    for (int t = 0; t < NSCHED; t++) sched[t] = -1;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0; paddr[r] = '0; last[r] = '0; req_en[r] = 1'b0; req_addr[r] = '0;
    end
    mdata = '0;
    rst = 1'b1;
    @(negedge clk);
    apply_reset(3);

    // All three request together: i first, then d, then c as each is granted.
    request(0); request(1); request(2);
    for (int k = 0; k < 3 + LAT; k++) step();

    // d and c held with i idle.
    request(1); step(); request(1); step(); request(1); request(2); step();
    for (int k = 0; k < 2 + LAT; k++) step();

    // Alternating i/c grants every cycle.
    for (int k = 0; k < 8; k++) begin
      request((k % 2 == 0) ? 0 : 2);
      step();
    end
    for (int k = 0; k < LAT + 1; k++) step();

    // Reset one cycle after a d grant drops the in-flight read.
    request(1); step(); step();
    apply_reset(2);
    for (int k = 0; k < LAT + 1; k++) step();
    request(0); step();
    for (int k = 0; k < LAT + 1; k++) step();

    // Idle period.
    for (int k = 0; k < 20; k++) step();

    // Randomized traffic with hold-until-grant requesters and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      for (int r = 0; r < 3; r++) if (!pend[r] && $urandom_range(0, 99) < 45) request(r);
      if ($urandom_range(0, 299) == 0) apply_reset(1);
      else step();
    end
    for (int k = 0; k < LAT + 2; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
